vga_text_render: RTL and testbench
==================================

Name: vga_text_render

Overview:
- Text-mode front end feeding the VGA timing controller.
- Holds a 70x30 character buffer written from a byte stream, for example from the keyboard or CPU.
- Manages cursor, newline, backspace and hardware scrolling.
- Combinationally converts the controller's character coordinates into 24-bit pixel colour on vga_data.

Parameters:
- COLS, 70, characters per line (9-px cells).
- ROWS, 30, lines on screen (16-px cells).
- FG_COLOR, 24'hFFFFFF, foreground pixel colour.
- BG_COLOR, 24'h000000, background pixel colour.
- BLINK_BITS, 23, width of the cursor blink counter.

Ports:
- pclk  in  1  25 MHz pixel clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- ch_valid  in  1  input character valid.
- ch_data  in  8  input character code.
- ch_ready  out  1  block can accept a character this cycle.
- row_idx  in  5  character row from the controller (its h_count).
- col_idx  in  7  character column from the controller (its v_count).
- font_row  in  4  line within the cell, 0..15 (its h_ascii).
- font_col  in  4  pixel within the cell, 0..8 (its v_ascii).
- pix_valid  in  1  active-video flag from the controller.
- vga_data  out  24  pixel colour to the controller.
- cursor_row  out  5  logical cursor row.
- cursor_col  out  7  cursor column.

Behaviour:
- Reset (async assert, sync release):
  - ch_ready=0, cursor_row=0, cursor_col=0, top_row=0, init_done=0.
  - FSM goes to INIT; blink counter=0.
  - Reset asserted mid-INIT or mid-CLEAR aborts the operation and restarts INIT after release.
- FSM states: INIT, IDLE, CLEAR.
  - INIT: writes 8'h20 to all COLS*ROWS cells, one per cycle, in address order (2100 cycles). Then sets init_done=1 and goes to IDLE.
  - IDLE: ch_ready=1. A character is accepted on a rising pclk edge with ch_valid&&ch_ready. ch_data must be stable while valid.
  - CLEAR: ch_ready=0. Writes 8'h20 to the COLS cells of one physical row (70 cycles), then returns to IDLE.
- Physical row = (logical row + top_row) mod ROWS, done by add and conditional subtract. Cell address = phys_row*COLS + col.
- Accepted character handling:
  - 0x20..0x7E: write the code at the cursor cell; cursor_col+1. If the result equals COLS, perform a newline.
  - 0x0A (LF): cursor_col=0; perform a newline.
  - 0x0D (CR): cursor_col=0 only.
  - 0x08 (BS): if cursor_col>0, decrement it and write 0x20 to the new cell. At col 0, no effect.
  - Any other code is accepted and dropped.
- Newline:
  - cursor_row<ROWS-1: cursor_row+1.
  - Otherwise scroll: top_row=(top_row+1) mod ROWS, cursor_row stays ROWS-1, FSM enters CLEAR on the new bottom physical row (the old top_row).
- Scroll timing: the accepting cycle updates state. ch_ready drops the next cycle for exactly COLS cycles.
- Memory: character RAM has one synchronous write port and one asynchronous read port for display. Display reads never stall writes.
- Pixel path (zero latency, purely combinational from the row_idx/col_idx/font_row/font_col/pix_valid inputs and the registered top_row and RAM contents):
  - vga_data=BG_COLOR if pix_valid=0, init_done=0, row_idx>=ROWS, col_idx>=COLS, or font_col>8.
  - Otherwise vga_data=FG_COLOR when font bit [code][font_row][font_col]=1, else BG_COLOR.
  - Column 8 of every glyph is blank.

Optional Feature:
- CURSOR_BLINK_EN
  - Defined: free-running BLINK_BITS counter on pclk. While its MSB=1, the cell at (cursor_row, cursor_col) shows FG_COLOR on font_row 14 and 15 regardless of glyph. While MSB=0 the cell renders normally.
  - Undefined: no counter, no cursor drawn.

Decomposition:
- Package vga_text_pkg: COLS, ROWS, CHAR_W=9, CHAR_H=16, SPACE=8'h20, LF/CR/BS codes, FSM state enum, address width localparams.
- Sub-module vga_font_rom: 256x16 entries of 9 bits, asynchronous read, indexed by {code, font_row}.

Test Plan:
- Release reset -> ch_ready=0 for exactly 2100 cycles then 1. Every active pixel is 24'h000000 throughout.
- Send 0x41 -> cursor (0,1). Pixels of row_idx=0, col_idx=0 equal FG where the ROM 'A' bits are 1, BG elsewhere. Column font_col=8 is BG.
- Send 70 x 0x41 -> cursor (1,0). Send 0x0D -> cursor_col=0, row unchanged.
- Cursor at row 29, send 0x0A -> ch_ready=0 for 70 cycles. top_row=1, cursor (29,0). Old row 1 content is displayed at row_idx 0; row_idx 29 is blank.
- Cursor col 5, send 0x08 -> cursor_col=4, cell 4 renders BG. Send 0x08 at col 0 -> no change. Send 0x07 -> accepted, nothing changes.
- pix_valid=0, col_idx=70, or row_idx=30 -> vga_data=24'h000000. Reset asserted during CLEAR -> outputs return to reset values immediately and INIT reruns.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared geometry, control codes, FSM states and addressing helpers for the text renderer.
package vga_text_pkg;

  localparam int unsigned COLS   = 70;
  localparam int unsigned ROWS   = 30;
  localparam int unsigned CHAR_W = 9;
  localparam int unsigned CHAR_H = 16;
  localparam int unsigned CELLS  = COLS * ROWS;

  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned SUM_W  = ROW_W + 1;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // Logical-to-physical row for the circular scroll buffer.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                input logic [ROW_W-1:0] top);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= SUM_W'(ROWS)) sum = sum - SUM_W'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_font_rom.sv
// Glyph ROM: 256 codes x 16 lines x 9 pixels, asynchronous read indexed by {code, line}.
// Printable ASCII uses a 5x7 face doubled vertically onto lines 1..14, pixel columns 1..5.
module vga_font_rom
  import vga_text_pkg::*;
(
  input  logic [7:0]                code_i,
  input  logic [$clog2(CHAR_H)-1:0] line_i,
  output logic [CHAR_W-1:0]         bits_o
);

  // Five column bytes, leftmost first; bit 0 of each byte is the top dot.
  function automatic logic [39:0] glyph(input logic [7:0] code);
    logic [39:0] g;
    case (code)
      8'h21: g = 40'h00_00_5F_00_00;  8'h22: g = 40'h00_07_00_07_00;
      8'h23: g = 40'h14_7F_14_7F_14;  8'h24: g = 40'h24_2A_7F_2A_12;
      8'h25: g = 40'h23_13_08_64_62;  8'h26: g = 40'h36_49_55_22_50;
      8'h27: g = 40'h00_05_03_00_00;  8'h28: g = 40'h00_1C_22_41_00;
      8'h29: g = 40'h00_41_22_1C_00;  8'h2A: g = 40'h08_2A_1C_2A_08;
      8'h2B: g = 40'h08_08_3E_08_08;  8'h2C: g = 40'h00_50_30_00_00;
      8'h2D: g = 40'h08_08_08_08_08;  8'h2E: g = 40'h00_60_60_00_00;
      8'h2F: g = 40'h20_10_08_04_02;  8'h30: g = 40'h3E_51_49_45_3E;
      8'h31: g = 40'h00_42_7F_40_00;  8'h32: g = 40'h42_61_51_49_46;
      8'h33: g = 40'h21_41_45_4B_31;  8'h34: g = 40'h18_14_12_7F_10;
      8'h35: g = 40'h27_45_45_45_39;  8'h36: g = 40'h3C_4A_49_49_30;
      8'h37: g = 40'h01_71_09_05_03;  8'h38: g = 40'h36_49_49_49_36;
      8'h39: g = 40'h06_49_49_29_1E;  8'h3A: g = 40'h00_36_36_00_00;
      8'h3B: g = 40'h00_56_36_00_00;  8'h3C: g = 40'h08_14_22_41_00;
      8'h3D: g = 40'h14_14_14_14_14;  8'h3E: g = 40'h00_41_22_14_08;
      8'h3F: g = 40'h02_01_51_09_06;  8'h40: g = 40'h32_49_79_41_3E;
      8'h41: g = 40'h7E_11_11_11_7E;  8'h42: g = 40'h7F_49_49_49_36;
      8'h43: g = 40'h3E_41_41_41_22;  8'h44: g = 40'h7F_41_41_22_1C;
      8'h45: g = 40'h7F_49_49_49_41;  8'h46: g = 40'h7F_09_09_01_01;
      8'h47: g = 40'h3E_41_41_51_32;  8'h48: g = 40'h7F_08_08_08_7F;
      8'h49: g = 40'h00_41_7F_41_00;  8'h4A: g = 40'h20_40_41_3F_01;
      8'h4B: g = 40'h7F_08_14_22_41;  8'h4C: g = 40'h7F_40_40_40_40;
      8'h4D: g = 40'h7F_02_04_02_7F;  8'h4E: g = 40'h7F_04_08_10_7F;
      8'h4F: g = 40'h3E_41_41_41_3E;  8'h50: g = 40'h7F_09_09_09_06;
      8'h51: g = 40'h3E_41_51_21_5E;  8'h52: g = 40'h7F_09_19_29_46;
      8'h53: g = 40'h46_49_49_49_31;  8'h54: g = 40'h01_01_7F_01_01;
      8'h55: g = 40'h3F_40_40_40_3F;  8'h56: g = 40'h1F_20_40_20_1F;
      8'h57: g = 40'h7F_20_18_20_7F;  8'h58: g = 40'h63_14_08_14_63;
      8'h59: g = 40'h03_04_78_04_03;  8'h5A: g = 40'h61_51_49_45_43;
      8'h5B: g = 40'h00_7F_41_41_00;  8'h5C: g = 40'h02_04_08_10_20;
      8'h5D: g = 40'h00_41_41_7F_00;  8'h5E: g = 40'h04_02_01_02_04;
      8'h5F: g = 40'h40_40_40_40_40;  8'h60: g = 40'h00_01_02_04_00;
      8'h61: g = 40'h20_54_54_54_78;  8'h62: g = 40'h7F_48_44_44_38;
      8'h63: g = 40'h38_44_44_44_20;  8'h64: g = 40'h38_44_44_48_7F;
      8'h65: g = 40'h38_54_54_54_18;  8'h66: g = 40'h08_7E_09_01_02;
      8'h67: g = 40'h08_14_54_54_3C;  8'h68: g = 40'h7F_08_04_04_78;
      8'h69: g = 40'h00_44_7D_40_00;  8'h6A: g = 40'h20_40_44_3D_00;
      8'h6B: g = 40'h00_7F_10_28_44;  8'h6C: g = 40'h00_41_7F_40_00;
      8'h6D: g = 40'h7C_04_18_04_78;  8'h6E: g = 40'h7C_08_04_04_78;
      8'h6F: g = 40'h38_44_44_44_38;  8'h70: g = 40'h7C_14_14_14_08;
      8'h71: g = 40'h08_14_14_18_7C;  8'h72: g = 40'h7C_08_04_04_08;
      8'h73: g = 40'h48_54_54_54_20;  8'h74: g = 40'h04_3F_44_40_20;
      8'h75: g = 40'h3C_40_40_20_7C;  8'h76: g = 40'h1C_20_40_20_1C;
      8'h77: g = 40'h3C_40_30_40_3C;  8'h78: g = 40'h44_28_10_28_44;
      8'h79: g = 40'h0C_50_50_50_3C;  8'h7A: g = 40'h44_64_54_4C_44;
      8'h7B: g = 40'h00_08_36_41_00;  8'h7C: g = 40'h00_00_7F_00_00;
      8'h7D: g = 40'h00_41_36_08_00;  8'h7E: g = 40'h08_04_08_10_08;
      default: g = '0;
    endcase
    return g;
  endfunction

  logic [39:0] cols;
  logic [2:0]  dot_row;

  always_comb begin
    cols    = glyph(code_i);
    dot_row = 3'((line_i - 4'd1) >> 1);
    bits_o  = '0;
    if (line_i >= 4'd1 && line_i <= 4'd14) begin
      for (int unsigned x = 0; x < 5; x++) begin
        bits_o[x + 1] = cols[(4 - x) * 8 + 32'(dot_row)];
      end
    end
  end

endmodule

// File: rtl/vga_text_render.sv
// Text-mode front end: character buffer with cursor/scroll control and combinational pixel output.
// Optional CURSOR_BLINK_EN draws a blinking underline cursor on lines 14..15 of the cursor cell.
module vga_text_render
  import vga_text_pkg::*;
#(
  parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR   = 24'h000000,
  parameter int unsigned BLINK_BITS = 23
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             ch_valid,
  input  logic [7:0]       ch_data,
  output logic             ch_ready,
  input  logic [ROW_W-1:0] row_idx,
  input  logic [COL_W-1:0] col_idx,
  input  logic [3:0]       font_row,
  input  logic [3:0]       font_col,
  input  logic             pix_valid,
  output logic [23:0]      vga_data,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col
);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] clr_base_q;
  logic [ROW_W-1:0]  top_q;
  logic [ROW_W-1:0]  cur_row_q;
  logic [COL_W-1:0]  cur_col_q;
  logic              ready_q;
  logic              init_done_q;

  logic [7:0]        mem [CELLS];

  logic              accept;
  logic              printable;
  logic              at_last_col;
  logic              at_last_row;
  logic              newline;
  logic [ADDR_W-1:0] cur_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  assign ch_ready   = ready_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;

  always_comb begin
    accept      = ch_valid && ready_q;
    printable   = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
    at_last_col = (cur_col_q == COL_W'(COLS - 1));
    at_last_row = (cur_row_q == ROW_W'(ROWS - 1));
    newline     = accept && ((printable && at_last_col) || (ch_data == LF));
    cur_addr    = cell_addr(phys_row(cur_row_q, top_q), cur_col_q);
    wr_en       = 1'b0;
    wr_addr     = cnt_q;
    wr_data     = SPACE;
    case (state_q)
      ST_INIT:  wr_en = 1'b1;
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_base_q + cnt_q;
      end
      default: begin
        if (accept && printable) begin
          wr_en   = 1'b1;
          wr_addr = cur_addr;
          wr_data = ch_data;
        end else if (accept && ch_data == BS && cur_col_q != '0) begin
          wr_en   = 1'b1;
          wr_addr = cur_addr - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      clr_base_q  <= '0;
      top_q       <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q == ADDR_W'(CELLS - 1)) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            if (printable) cur_col_q <= at_last_col ? '0 : cur_col_q + 1'b1;
            else if (ch_data == LF || ch_data == CR) cur_col_q <= '0;
            else if (ch_data == BS && cur_col_q != '0) cur_col_q <= cur_col_q - 1'b1;
            // Scrolling advances top_q; the old top physical row becomes the new bottom line.
            if (newline) begin
              if (!at_last_row) begin
                cur_row_q <= cur_row_q + 1'b1;
              end else begin
                top_q      <= (top_q == ROW_W'(ROWS - 1)) ? '0 : top_q + 1'b1;
                clr_base_q <= cell_addr(top_q, '0);
                state_q    <= ST_CLEAR;
                ready_q    <= 1'b0;
                cnt_q      <= '0;
              end
            end
          end
        end
        ST_CLEAR: begin
          if (cnt_q == ADDR_W'(COLS - 1)) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  logic              in_cell;
  logic [ADDR_W-1:0] disp_addr;
  logic [7:0]        disp_code;
  logic [CHAR_W-1:0] glyph_bits;
  logic [15:0]       glyph_line;
  logic              cursor_lit;

  always_comb begin
    in_cell   = pix_valid && init_done_q && (row_idx < ROW_W'(ROWS)) &&
                (col_idx < COL_W'(COLS)) && (font_col < 4'(CHAR_W));
    disp_addr = in_cell ? cell_addr(phys_row(row_idx, top_q), col_idx) : '0;
  end

  assign disp_code = mem[disp_addr];

  vga_font_rom u_font (
    .code_i (disp_code),
    .line_i (font_row),
    .bits_o (glyph_bits)
  );

`ifdef CURSOR_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) blink_q <= '0;
    else        blink_q <= blink_q + 1'b1;
  end

  assign cursor_lit = blink_q[BLINK_BITS-1] && (row_idx == cur_row_q) &&
                      (col_idx == cur_col_q) && (font_row >= 4'd14);
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_BITS == 0);
  assign cursor_lit       = 1'b0;
`endif

  always_comb begin
    glyph_line = 16'(glyph_bits);
    vga_data   = (in_cell && (glyph_line[font_col] || cursor_lit)) ? FG_COLOR : BG_COLOR;
  end

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render: directed steps plus random traffic against a logical-screen model.
module tb_vga_text_render;

  localparam int ROWS = 30;
  localparam int COLS = 70;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        pclk;
  logic        reset;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [4:0]  row_idx;
  logic [6:0]  col_idx;
  logic [3:0]  font_row;
  logic [3:0]  font_col;
  logic        pix_valid;
  logic [23:0] vga_data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] scr [ROWS][COLS];
  int  m_row, m_col;
  bit  scrolled;
  logic [7:0] pool [10] = '{8'h41, 8'h48, 8'h30, 8'h78, 8'h20, 8'h0A, 8'h0D, 8'h08, 8'h07, 8'h7F};

  vga_text_render #(.FG_COLOR(FG), .BG_COLOR(BG), .BLINK_BITS(23)) dut (
    .pclk(pclk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .row_idx(row_idx), .col_idx(col_idx), .font_row(font_row), .font_col(font_col),
    .pix_valid(pix_valid), .vga_data(vga_data), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  initial pclk = 1'b0;
  always #20 pclk = ~pclk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 5x7 face: five column bytes, leftmost first, bit 0 = top dot.
  function automatic logic [39:0] font(input logic [7:0] c);
    case (c)
      8'h41:   return 40'h7E_11_11_11_7E;
      8'h48:   return 40'h7F_08_08_08_7F;
      8'h30:   return 40'h3E_51_49_45_3E;
      8'h78:   return 40'h44_28_10_28_44;
      default: return 40'h0;
    endcase
  endfunction

  // Dots are doubled vertically onto lines 1..14 and occupy pixel columns 1..5.
  function automatic logic [23:0] expect_pix(input int r, input int c, input int fr,
                                             input int fc, input bit pv);
    logic [39:0] g;
    logic [7:0]  colbits;
    if (!pv || r >= ROWS || c >= COLS || fc > 8) return BG;
    if (fr < 1 || fr > 14 || fc < 1 || fc > 5) return BG;
    g = font(scr[r][c]);
    colbits = g[(5 - fc) * 8 +: 8];
    return colbits[(fr - 1) / 2] ? FG : BG;
  endfunction

  task automatic pix(input int r, input int c, input int fr, input int fc, input bit pv,
                     input string tag);
    row_idx = 5'(r); col_idx = 7'(c); font_row = 4'(fr); font_col = 4'(fc); pix_valid = pv;
    #1;
    check(tag, 32'(vga_data), 32'(expect_pix(r, c, fr, fc, pv)));
  endtask

  task automatic check_cell(input int r, input int c, input string tag);
    for (int fr = 0; fr < 16; fr++)
      for (int fc = 0; fc < 16; fc++)
        pix(r, c, fr, fc, 1'b1, tag);
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = 8'h20;
    m_row = 0; m_col = 0;
  endtask

  task automatic model_nl();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r + 1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = 8'h20;
      scrolled = 1'b1;
    end
  endtask

  task automatic model_put(input logic [7:0] c);
    scrolled = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[m_row][m_col] = c;
      m_col++;
      if (m_col == COLS) begin m_col = 0; model_nl(); end
    end else if (c == 8'h0A) begin
      m_col = 0; model_nl();
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h08 && m_col > 0) begin
      m_col--; scr[m_row][m_col] = 8'h20;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge pclk);
    while (!ch_ready && n < 500) begin @(negedge pclk); n++; end
    check(tag, 32'(ch_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    wait_ready("ready_before_send");
    ch_valid = 1'b1; ch_data = c;
    @(posedge pclk); #1;
    ch_valid = 1'b0;
    model_put(c);
    if (scrolled) begin
      n = 0;
      while (!ch_ready && n < 200) begin @(posedge pclk); #1; n++; end
      check("clear_busy_cycles", 32'(n), 32'd70);
    end else begin
      check("ready_after_send", 32'(ch_ready), 32'd1);
    end
    check("cursor_row", 32'(cursor_row), 32'(m_row));
    check("cursor_col", 32'(cursor_col), 32'(m_col));
  endtask

  task automatic wait_init();
    int n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
      if (n % 50 == 0)
        pix($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
            $urandom_range(0, 15), $urandom_range(0, 8), 1'b1, "init_pix");
    end while (!ch_ready && n < 3000);
    check("init_cycles", 32'(n), 32'd2100);
  endtask

  initial begin
    reset = 1'b0; ch_valid = 1'b0; ch_data = 8'h00;
    row_idx = '0; col_idx = '0; font_row = '0; font_col = '0; pix_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check("reset_ready", 32'(ch_ready), 32'd0);
    check("reset_cur_row", 32'(cursor_row), 32'd0);
    check("reset_cur_col", 32'(cursor_col), 32'd0);
    pix(0, 0, 3, 2, 1'b1, "reset_pix");

    reset = 1'b1;
    wait_init();
    for (int i = 0; i < 20; i++)
      pix($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
          $urandom_range(0, 15), $urandom_range(0, 15), 1'b1, "blank_pix");

    send(8'h41);
    check_cell(0, 0, "cell_A");
    repeat (69) send(8'h41);
    send(8'h48);
    send(8'h0D);
    repeat (28) send(8'h0A);
    send(8'h78);
    send(8'h78);
    send(8'h0A);
    check_cell(0, 0, "scroll_row0_H");
    check_cell(29, 0, "scroll_row29_blank");
    check_cell(28, 1, "scroll_row28_x");

    repeat (5) send(8'h30);
    send(8'h08);
    check_cell(29, 4, "bs_cell4_blank");
    check_cell(29, 3, "bs_cell3_zero");
    send(8'h0D);
    send(8'h08);
    send(8'h07);

    pix(28, 0, 5, 1, 1'b1, "edge_fg_pixel");
    pix(28, 0, 5, 1, 1'b0, "edge_pix_valid0");
    pix(28, 70, 5, 1, 1'b1, "edge_col70");
    pix(30, 0, 5, 1, 1'b1, "edge_row30");
    pix(28, 127, 5, 1, 1'b1, "edge_col127");
    pix(31, 0, 5, 1, 1'b1, "edge_row31");
    for (int fc = 8; fc < 16; fc++) pix(0, 0, 3, fc, 1'b1, "edge_fontcol");

    for (int i = 0; i < 400; i++) begin
      send(pool[$urandom_range(0, 9)]);
      for (int k = 0; k < 4; k++)
        pix($urandom_range(0, 31), $urandom_range(0, 71), $urandom_range(0, 15),
            $urandom_range(0, 9), ($urandom_range(0, 7) != 0), "rand_pix");
    end

    while (m_row < ROWS - 1) send(8'h0A);
    wait_ready("ready_before_abort");
    ch_valid = 1'b1; ch_data = 8'h0A;
    @(posedge pclk); #1;
    ch_valid = 1'b0;
    model_put(8'h0A);
    repeat (10) @(posedge pclk);
    #1;
    check("mid_clear_busy", 32'(ch_ready), 32'd0);
    reset = 1'b0;
    #1;
    model_reset();
    check("abort_ready", 32'(ch_ready), 32'd0);
    check("abort_cur_row", 32'(cursor_row), 32'd0);
    check("abort_cur_col", 32'(cursor_col), 32'd0);
    pix(0, 0, 5, 1, 1'b1, "abort_pix");
    @(posedge pclk); #1;
    reset = 1'b1;
    wait_init();
    check_cell(28, 0, "reinit_blank");
    send(8'h41);
    check_cell(0, 0, "reinit_A");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
